rr_mux_reg: RTL and testbench
=============================

# rr_mux_reg

Parametrised, registered N-channel by W-bit multiplexer with per-channel valid/ready handshakes. It selects either by an external select or by a round-robin arbiter, and presents the chosen word through a single output register. It is the next-generation replacement for the fixed 4:1 combinational 1-bit mux. It sits between several producer channels and one consumer and supports back-pressure.

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `DW`, default 8: data width per channel, 1..64.
- `SW` (local), `$clog2(N_CH)`: select and channel-index width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in N_CH: channel k has a word.
- `in_data` in N_CH*DW: channel k occupies bits [k*DW +: DW].
- `in_ready` out N_CH: channel k word accepted this cycle when `in_valid[k] && in_ready[k]`.
- `mode` in 1: 0 selects round-robin, 1 selects fixed select.
- `sel` in SW: channel used when `mode=1`.
- `out_valid` out 1: registered output holds a word.
- `out_data` out DW: registered word.
- `out_ch` out SW: source channel of `out_data`.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `in_last` in N_CH (only with `RR_MUX_PKT_LOCK_EN`): marks the final beat of a packet.
- `out_last` out 1 (only with `RR_MUX_PKT_LOCK_EN`): registered copy of the accepted `in_last`.

## Operation
- `load = !out_valid || out_ready`: the output register can take a new word this cycle.
- Grant logic is combinational and produces at most one-hot `gnt`.
  - Mode 1: `gnt[sel] = in_valid[sel]`. Out-of-range `sel` (>= N_CH) grants nothing.
  - Mode 0: search channels `ptr, ptr+1, … ptr+N_CH-1` (mod N_CH). The first one with `in_valid` set wins.
- `in_ready = gnt & {N_CH{load}}`. All bits are forced to 0 while `rst_n=0`.
- Accept on the clock edge when a granted channel is valid and `load` is high:
  - `out_data` takes that channel's word, `out_ch` takes its index, `out_valid` goes to 1.
  - In mode 0, `ptr` advances to (granted index + 1) mod N_CH. `ptr` wraps N_CH-1 → 0.
- If `load` is high and nothing is granted, `out_valid` goes to 0 and `out_data`/`out_ch` hold their values.
- If `load` is low, everything holds.
- `ptr` is unchanged in mode 1. A mode change takes effect on the next grant evaluation.
- State machine (round-robin arbiter): `ptr` is the only state; valid range 0..N_CH-1.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`, lock state cleared, `out_last=0`, `in_ready=0`.
- Reset asserted mid-transfer discards the output word immediately, asynchronously.
- Latency: a word accepted at edge t is visible on `out_*` after edge t.
- Throughput is 1 word/cycle when `out_ready` is held high.
- A simultaneous output drain and new accept in the same cycle is legal and required (no bubble).
- Inputs must hold `in_valid`/`in_data` stable until accepted. The block does not check this.
- `out_data`/`out_valid` must not change while `out_valid && !out_ready`.

## Configuration
- `RR_MUX_PKT_LOCK_EN` defined:
  - Adds `in_last`/`out_last` and a lock flag with locked index.
  - On accepting a beat with `in_last=0`, the grant locks to that channel until a beat with `in_last=1` is accepted from it. This applies in both modes; `sel` and round-robin are ignored while locked.
  - `ptr` advances only when the last beat is accepted.
- `RR_MUX_PKT_LOCK_EN` undefined:
  - No `in_last`/`out_last` ports; every beat is arbitrated independently.

## Test plan
- Reset, then mode 1, `sel=2`, `in_valid=4'b0100`, `in_data[2]=8'hA5`, `out_ready=1` → `in_ready=4'b0100`; next cycle `out_valid=1`, `out_data=A5`, `out_ch=2`.
- Mode 0, all four valid continuously, `out_ready=1` → `out_ch` sequence 0,1,2,3,0 on consecutive cycles; `ptr` wraps.
- Mode 0, `in_valid=4'b1001` with `ptr=1` → channel 3 granted first, then channel 0.
- Output holding A5 with `out_ready=0` for 3 cycles, channel 1 valid → `in_ready=0`, `out_data` stays A5; on `out_ready=1` same-cycle accept of channel 1 with no idle cycle.
- Assert `rst_n=0` while `out_valid=1` → `out_valid=0`, `out_data=0`, `in_ready=0` immediately; first grant after release comes from `ptr=0`.
- With `RR_MUX_PKT_LOCK_EN`, channel 1 sends a 3-beat packet (`in_last` on beat 3) while channel 2 is valid → beats 1,1,1 then channel 2; `out_last=1` only on the third beat.

Source files
------------

// File: rtl/rr_mux_reg.sv
// Registered N-channel round-robin / fixed-select multiplexer with valid/ready handshakes.
// Define RR_MUX_PKT_LOCK_EN to add packet locking with in_last/out_last.
module rr_mux_reg #(
    parameter  int N_CH = 4,
    parameter  int DW   = 8,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [N_CH-1:0]    in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_ch,
    input  logic               out_ready
`ifdef RR_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]    in_last,
    output logic               out_last
`endif
);

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [SW-1:0] r_out_ch;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_gnt_valid;
    logic [SW-1:0] w_gnt_idx;
    logic [SW-1:0] w_cand;
    logic [SW-1:0] w_ptr_next;
    logic [DW-1:0] w_gnt_data;
    int            w_idx;

`ifdef RR_MUX_PKT_LOCK_EN
    logic          r_locked;
    logic [SW-1:0] r_lock_ch;
    logic          r_out_last;
`endif

    assign w_load = !r_out_valid || out_ready;

    // Descending scan so the candidate closest to ptr is the last one written.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        w_idx       = 0;
        if (mode) begin
            if (32'(sel) < N_CH) begin
                w_gnt_idx   = sel;
                w_gnt_valid = in_valid[sel];
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                w_idx = int'(r_ptr) + i;
                if (w_idx >= N_CH) w_idx = w_idx - N_CH;
                w_cand = SW'(w_idx);
                if (in_valid[w_cand]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = w_cand;
                end
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        if (r_locked) begin
            w_gnt_idx   = r_lock_ch;
            w_gnt_valid = in_valid[r_lock_ch];
        end
`endif
    end

    always_comb begin
        w_gnt_data = in_data[w_gnt_idx*DW +: DW];
        if (32'(w_gnt_idx) == N_CH - 1) w_ptr_next = '0;
        else                            w_ptr_next = w_gnt_idx + 1'b1;
    end

    // Ready is gated by rst_n so no producer sees an accept while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && w_load && w_gnt_valid) in_ready[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_ch   <= '0;
            r_out_last  <= 1'b0;
`endif
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
`ifdef RR_MUX_PKT_LOCK_EN
                r_out_last  <= in_last[w_gnt_idx];
                r_locked    <= !in_last[w_gnt_idx];
                r_lock_ch   <= w_gnt_idx;
                if (!mode && in_last[w_gnt_idx]) r_ptr <= w_ptr_next;
`else
                if (!mode) r_ptr <= w_ptr_next;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
`ifdef RR_MUX_PKT_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomised scoreboard bench for rr_mux_reg (default build, no packet lock).
// A transaction-level model predicts accepts; a separate monitor checks the output register.
module tb_rr_mux_reg;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } item_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_ch;
    logic            out_ready;

    item_t           expQ[$];
    logic [N-1:0]    pendValid;
    logic [DW-1:0]   pendData [N];
    int              mPtr;
    bit              mFull;
    bit              monEn;
    int              tests;
    int              fails;

    rr_mux_reg #(.N_CH(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner chosen directly from the arbitration rules: fixed select, or the
    // first valid channel walking forward from the round-robin pointer.
    function automatic int expGrant(input logic m, input int s, input logic [N-1:0] v, input int p);
        if (m) return (s < N && v[s]) ? s : -1;
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] newMask, input logic modeV, input logic [SW-1:0] selV,
                                 input logic readyV, input logic useData, input logic [DW-1:0] dataV);
        int           g;
        bit           load;
        logic [N-1:0] expRdy;
        @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (newMask[k] && !pendValid[k]) begin
                pendValid[k] = 1'b1;
                pendData[k]  = useData ? dataV : DW'($urandom);
            end
            in_data[k*DW +: DW] = pendData[k];
        end
        in_valid  = pendValid;
        mode      = modeV;
        sel       = selV;
        out_ready = readyV;
        #1;
        checkOutput("out_valid", 64'(out_valid), 64'(mFull));
        load   = !mFull || readyV;
        g      = expGrant(modeV, int'(selV), pendValid, mPtr);
        expRdy = (load && g >= 0) ? (N'(1) << g) : '0;
        checkOutput("in_ready", 64'(in_ready), 64'(expRdy));
        if (load) begin
            if (g >= 0) begin
                expQ.push_back('{g, pendData[g]});
                mFull        = 1'b1;
                pendValid[g] = 1'b0;
                if (!modeV) mPtr = (g + 1) % N;
            end else begin
                mFull = 1'b0;
            end
        end
    endtask

    // Monitor: samples just before the active edge, pops on each output handshake.
    always begin
        @(negedge clk);
        #3;
        if (monEn && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                checkOutput("out_data", 64'(out_data), 64'(expQ[0].data));
                checkOutput("out_ch", 64'(out_ch), 64'(expQ[0].ch));
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic resetModel();
        expQ.delete();
        pendValid = '0;
        in_valid  = '0;
        mPtr      = 0;
        mFull     = 1'b0;
    endtask

    initial begin
        logic [N-1:0] m;
        logic         rMode;
        tests     = 0;
        fails     = 0;
        monEn     = 1'b0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_valid  = '1;
        in_data   = '1;
        for (int k = 0; k < N; k++) pendData[k] = '0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_ch", 64'(out_ch), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        monEn = 1'b1;

        applyStimulus(4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA5);
        for (int c = 0; c < 5; c++) applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0);

        applyStimulus(4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA5);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, '0);
        applyStimulus(4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, '0);

        @(negedge clk);
        #1;
        monEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_out_data", 64'(out_data), 64'd0);
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        monEn = 1'b1;

        applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        applyStimulus(4'b1001, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0);

        rMode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) m[k] = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) == 0) rMode = ~rMode;
            applyStimulus(m, rMode, SW'($urandom_range(0, N - 1)), ($urandom_range(0, 9) < 7), 1'b0, '0);
        end
        for (int c = 0; c < 8; c++) applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, '0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
